// File: rtl/axis_adc_burst_if.sv
// AXI4-Stream bundle used for the one-word config slave and the sample master.
interface axis_adc_burst_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic             tlast;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_adc_burst.sv
// SPI ADC burst reader: triggered or continuous frames over NUM_SDI lanes,
// each result emitted on a single-register AXI4-Stream master with TLAST framing.
module axis_adc_burst #(
  parameter int NUM_SDI    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int SCK_DIV    = 1,
  parameter int GAP_CYCLES = 4
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               trigger,
  input  logic [NUM_SDI-1:0] spi_sdi,
  output logic               spi_sdo,
  output logic               spi_csn,
  output logic               spi_sck,
  axis_adc_burst_if.slave    s_axis,
  axis_adc_burst_if.master   m_axis,
  output logic               busy,
  output logic               overrun,
  output logic               trig_miss
);
  localparam int NUM_BITS = DATA_WIDTH / NUM_SDI;
  localparam int BIT_W    = (NUM_BITS > 1)   ? $clog2(NUM_BITS)   : 1;
  localparam int DIV_W    = (SCK_DIV > 1)    ? $clog2(SCK_DIV)    : 1;
  localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  state_t state_q, state_d;

  logic                  trig_q, ready_q, csn_q, sck_q;
  logic                  tvalid_q, tlast_q, overrun_q, trig_miss_q;
  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [GAP_W-1:0]      gap_cnt;
  logic [15:0]           cfg_len, frame_cnt;
  logic                  cfg_cont, run_cont;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, tdata_q;
  logic                  start, sck_toggle, sample, last_sample, gap_done, out_free;
  logic                  unused_cfg;

  assign start       = trigger && !trig_q;
  assign sck_toggle  = (state_q == SHIFT) && (div_cnt == DIV_W'(SCK_DIV - 1));
  // Sampling happens on the aclk edge that takes SCK from high to low.
  assign sample      = sck_toggle && sck_q;
  assign last_sample = sample && (bit_cnt == BIT_W'(NUM_BITS - 1));
  assign gap_done    = (state_q == GAP) && (gap_cnt == GAP_W'(GAP_CYCLES - 1));
  assign out_free    = !tvalid_q || m_axis.tready;
  assign shift_d     = (shift_q << NUM_SDI) | DATA_WIDTH'(spi_sdi);
  assign unused_cfg  = ^{s_axis.tdata[31:17], s_axis.tlast};

  always_comb begin
    // NOTE: default assigned first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_sample) state_d = GAP;
      GAP:     if (gap_done) state_d = (frame_cnt != '0 || run_cont) ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      trig_q      <= 1'b0;
      ready_q     <= 1'b0;
      csn_q       <= 1'b1;
      sck_q       <= 1'b0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      shift_q     <= '0;
      cfg_len     <= '0;
      cfg_cont    <= 1'b0;
      frame_cnt   <= '0;
      run_cont    <= 1'b0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
      overrun_q   <= 1'b0;
      trig_miss_q <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q  <= trigger;
      ready_q <= 1'b1;
      csn_q   <= (state_d != SHIFT);
      if (sck_toggle) sck_q <= !sck_q;
      div_cnt <= (state_q != SHIFT || sck_toggle) ? '0 : div_cnt + 1'b1;
      gap_cnt <= (state_q != GAP) ? '0 : gap_cnt + 1'b1;

      if (state_q != SHIFT || last_sample) bit_cnt <= '0;
      else if (sample)                     bit_cnt <= bit_cnt + 1'b1;
      if (sample) shift_q <= shift_d;

      if (s_axis.tvalid) begin
        cfg_len  <= s_axis.tdata[15:0];
        cfg_cont <= s_axis.tdata[16];
      end

      // The run's continuous flag is refreshed at each frame end, after TLAST
      // for that frame has been decided from the previous value.
      if (state_q == IDLE && start) begin
        frame_cnt <= cfg_len;
        run_cont  <= cfg_cont;
      end else begin
        if (gap_done && frame_cnt != '0) frame_cnt <= frame_cnt - 1'b1;
        if (last_sample) run_cont <= cfg_cont;
      end

      if (last_sample && out_free) begin
        tvalid_q <= 1'b1;
        tdata_q  <= shift_d;
        tlast_q  <= (frame_cnt == '0) && !run_cont;
      end else if (m_axis.tready) begin
        tvalid_q <= 1'b0;
      end

      // A new event wins over a clear arriving in the same cycle.
      if (last_sample && !out_free)       overrun_q <= 1'b1;
      else if (s_axis.tvalid)             overrun_q <= 1'b0;
      if (start && state_q != IDLE)       trig_miss_q <= 1'b1;
      else if (s_axis.tvalid)             trig_miss_q <= 1'b0;
    end
  end

  assign spi_sdo       = 1'b0;
  assign spi_csn       = csn_q;
  assign spi_sck       = sck_q;
  assign s_axis.tready = ready_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign busy          = (state_q != IDLE);
  assign overrun       = overrun_q;
  assign trig_miss     = trig_miss_q;
endmodule

// File: tb/tb_axis_adc_burst.sv
// Bench for axis_adc_burst: two instances (2 lanes/div 1 and 4 lanes/div 3) driven
// by behavioural ADC models; beats are collected and compared to expected lists.
module tb_axis_adc_burst;
  localparam int GAP = 4;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic trigger = 1'b0;
  logic trigger3 = 1'b0;
  always #5 aclk = ~aclk;

  int vectors = 0;
  int miscompares = 0;

  // Instance A: NUM_SDI=2, SCK_DIV=1
  axis_adc_burst_if #(.WIDTH(32)) s_axis ();
  axis_adc_burst_if #(.WIDTH(32)) m_axis ();
  logic [1:0] spi_sdi;
  logic spi_sdo, spi_csn, spi_sck, busy, overrun, trig_miss;

  axis_adc_burst #(.NUM_SDI(2), .DATA_WIDTH(32), .SCK_DIV(1), .GAP_CYCLES(GAP)) dut (
    .aclk(aclk), .aresetn(aresetn), .trigger(trigger), .spi_sdi(spi_sdi),
    .spi_sdo(spi_sdo), .spi_csn(spi_csn), .spi_sck(spi_sck),
    .s_axis(s_axis), .m_axis(m_axis),
    .busy(busy), .overrun(overrun), .trig_miss(trig_miss)
  );

  // Instance B: NUM_SDI=4, SCK_DIV=3
  axis_adc_burst_if #(.WIDTH(32)) s_axis3 ();
  axis_adc_burst_if #(.WIDTH(32)) m_axis3 ();
  logic [3:0] spi_sdi3;
  logic spi_sdo3, spi_csn3, spi_sck3, busy3, overrun3, trig_miss3;

  axis_adc_burst #(.NUM_SDI(4), .DATA_WIDTH(32), .SCK_DIV(3), .GAP_CYCLES(GAP)) dut3 (
    .aclk(aclk), .aresetn(aresetn), .trigger(trigger3), .spi_sdi(spi_sdi3),
    .spi_sdo(spi_sdo3), .spi_csn(spi_csn3), .spi_sck(spi_sck3),
    .s_axis(s_axis3), .m_axis(m_axis3),
    .busy(busy3), .overrun(overrun3), .trig_miss(trig_miss3)
  );

  // ADC models: a new word is presented when CSN falls, MSB group first, and
  // the next group appears after each SCK falling edge.
  logic [31:0] adc_const = 32'h0000_0926;
  logic [31:0] adc_fifo[$];
  logic [31:0] adc_sr = '0;
  logic [31:0] adc_sr3 = '0;
  always @(negedge spi_csn) begin
    if (adc_fifo.size() != 0) adc_sr = adc_fifo.pop_front();
    else                      adc_sr = adc_const;
  end
  always @(negedge spi_sck)  adc_sr = adc_sr << 2;
  always @(negedge spi_csn3) adc_sr3 = 32'h0000_0926;
  always @(negedge spi_sck3) adc_sr3 = adc_sr3 << 4;
  assign spi_sdi  = adc_sr[31:30];
  assign spi_sdi3 = adc_sr3[31:28];

  // Output monitors, sampled on the falling edge.
  logic [32:0] got_q[$];
  int          got3_n = 0;
  logic [31:0] got3_data = '0;
  int          sck_rises = 0;
  int          sck3_rises = 0;
  always @(negedge aclk) begin
    if (m_axis.tvalid && m_axis.tready) got_q.push_back({m_axis.tlast, m_axis.tdata});
    if (m_axis3.tvalid && m_axis3.tready) begin
      got3_n++;
      got3_data = m_axis3.tdata;
    end
  end
  always @(posedge spi_sck)  sck_rises++;
  always @(posedge spi_sck3) sck3_rises++;

  // Randomised downstream ready, forced high every 8th cycle so a beat always
  // drains well before the next frame can end.
  logic rnd_mode = 1'b0;
  int   rcyc = 0;
  always @(posedge aclk) begin
    if (rnd_mode) begin
      #1;
      m_axis.tready = (rcyc % 8 == 0) || ($urandom_range(0, 1) == 1);
      rcyc++;
    end
  end

  typedef struct {
    logic [31:0] cfg;
    logic [31:0] word;
    int          beats;
  } vec_t;
  vec_t vecs[5];

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [31:0] data);
    s_axis.tdata  = data;
    s_axis.tvalid = 1'b1;
    tick();
    s_axis.tvalid = 1'b0;
  endtask

  task automatic pulse_trig();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  task automatic pulse_trig3();
    trigger3 = 1'b1;
    tick();
    trigger3 = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check({name, "_idle"}, busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, h, lead, lasts;
    logic [32:0] exp_q[$];

    vecs[0] = '{32'h0000_0000, 32'h0000_0926, 1};
    vecs[1] = '{32'h0000_0003, 32'h0000_0926, 4};
    vecs[2] = '{32'h0000_0001, 32'hFFFF_FFFF, 2};
    vecs[3] = '{32'hFFFE_0002, 32'hA5A5_5A5A, 3};
    vecs[4] = '{32'h0000_0000, 32'h8000_0001, 1};

    s_axis.tdata = '0;  s_axis.tvalid = 1'b0;  s_axis.tlast = 1'b0;
    s_axis3.tdata = '0; s_axis3.tvalid = 1'b0; s_axis3.tlast = 1'b0;
    m_axis.tready = 1'b1;
    m_axis3.tready = 1'b1;

    // Reset state
    tick(3);
    check("rst_csn", spi_csn, 1);
    check("rst_sck", spi_sck, 0);
    check("rst_sdo", spi_sdo, 0);
    check("rst_tvalid", m_axis.tvalid, 0);
    check("rst_tdata", m_axis.tdata, 0);
    check("rst_tlast", m_axis.tlast, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_trig_miss", trig_miss, 0);
    aresetn = 1'b1;
    tick(2);
    check("s_tready", s_axis.tready, 1);

    // Single frame: CSN width, SCK edges, beat, busy release timing
    got_q.delete();
    sck_rises = 0;
    pulse_trig();
    n = 0;
    while (!spi_csn && n < 200) begin
      n++;
      tick();
    end
    check("csn_low_cycles", n, 32);
    m = 1;
    while (busy && m < 50) begin
      tick();
      m++;
    end
    check("busy_release", m, GAP + 1);
    check("sck_rises", sck_rises, 16);
    tick(2);
    check("single_beats", got_q.size(), 1);
    if (got_q.size() > 0) begin
      check("single_data", got_q[0][31:0], 32'h926);
      check("single_last", got_q[0][32], 1);
    end

    // Table: config word, constant ADC word, expected beat count
    for (int r = 0; r < 5; r++) begin
      cfg_write(vecs[r].cfg);
      adc_const = vecs[r].word;
      got_q.delete();
      pulse_trig();
      wait_idle($sformatf("row%0d", r), 2000);
      tick(2);
      check($sformatf("row%0d_beats", r), got_q.size(), vecs[r].beats);
      for (int i = 0; i < got_q.size(); i++) begin
        check($sformatf("row%0d_data%0d", r, i), got_q[i][31:0], vecs[r].word);
        check($sformatf("row%0d_last%0d", r, i), got_q[i][32], (i == vecs[r].beats - 1));
      end
      check($sformatf("row%0d_overrun", r), overrun, 0);
    end
    adc_const = 32'h0000_0926;

    // Inter-frame CSN-high gap within a burst of 4
    cfg_write(32'h3);
    pulse_trig();
    for (int g = 0; g < 3; g++) begin
      n = 0;
      while (!spi_csn && n < 100) begin
        tick();
        n++;
      end
      h = 0;
      while (spi_csn && h < 50) begin
        h++;
        tick();
      end
      check($sformatf("gap%0d_cycles", g), h, GAP);
    end
    wait_idle("gap", 2000);
    tick(2);

    // Overrun: downstream stalled, second result of a 2-frame burst is dropped
    m_axis.tready = 1'b0;
    got_q.delete();
    adc_fifo.push_back(32'h0000_0111);
    adc_fifo.push_back(32'h0000_0222);
    cfg_write(32'h1);
    pulse_trig();
    wait_idle("ovr", 2000);
    check("ovr_flag", overrun, 1);
    check("ovr_tvalid", m_axis.tvalid, 1);
    check("ovr_held_data", m_axis.tdata, 32'h111);
    check("ovr_held_last", m_axis.tlast, 0);
    m_axis.tready = 1'b1;
    tick(2);
    check("ovr_beats", got_q.size(), 1);
    check("ovr_tvalid_drop", m_axis.tvalid, 0);
    cfg_write(32'h0);
    check("ovr_clear", overrun, 0);

    // Continuous mode stopped by a mid-frame config write
    got_q.delete();
    cfg_write(32'h0001_0000);
    pulse_trig();
    n = 0;
    while (got_q.size() < 3 && n < 1000) begin
      tick();
      n++;
    end
    check("cont_three_beats", got_q.size(), 3);
    n = 0;
    while (spi_csn && n < 50) begin
      tick();
      n++;
    end
    tick(5);
    cfg_write(32'h0);
    wait_idle("cont", 2000);
    tick(2);
    check("cont_beats", got_q.size(), 4);
    lasts = 0;
    foreach (got_q[i]) if (got_q[i][32]) lasts++;
    check("cont_no_tlast", lasts, 0);

    // Trigger while shifting: ignored and flagged
    got_q.delete();
    pulse_trig();
    tick(5);
    pulse_trig();
    wait_idle("miss", 2000);
    tick(2);
    check("miss_beats", got_q.size(), 1);
    check("miss_flag", trig_miss, 1);
    cfg_write(32'h0);
    check("miss_clear", trig_miss, 0);

    // Randomised bursts against an expected beat list built from burst rules
    got_q.delete();
    exp_q.delete();
    rnd_mode = 1'b1;
    for (int b = 0; b < 12; b++) begin
      int len;
      len = $urandom_range(0, 3);
      cfg_write(32'(len));
      for (int f = 0; f <= len; f++) begin
        logic [31:0] w;
        w = $urandom;
        adc_fifo.push_back(w);
        exp_q.push_back({(f == len), w});
      end
      pulse_trig();
      wait_idle($sformatf("rnd%0d", b), 2000);
    end
    rnd_mode = 1'b0;
    tick(2);
    m_axis.tready = 1'b1;
    tick(3);
    check("rnd_beats", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("rnd_beat%0d", i), got_q[i], exp_q[i]);
    check("rnd_overrun", overrun, 0);

    // Instance B: 4 lanes, SCK_DIV=3
    sck3_rises = 0;
    pulse_trig3();
    n = 0; h = 0; lead = 0;
    while (!spi_csn3 && n < 400) begin
      n++;
      if (spi_sck3) h++;
      else if (h == 0) lead++;
      tick();
    end
    check("b_csn_low_cycles", n, 48);
    check("b_sck_high_cycles", h, 24);
    check("b_sck_first_low", lead, 3);
    check("b_sck_rises", sck3_rises, 8);
    tick(GAP + 3);
    check("b_beats", got3_n, 1);
    check("b_data", got3_data, 32'h926);
    check("b_idle", busy3, 0);

    // Reset mid-frame: immediate abort, no beat
    pulse_trig3();
    tick(10);
    check("b_midframe_csn", spi_csn3, 0);
    aresetn = 1'b0;
    #1;
    check("b_rst_csn", spi_csn3, 1);
    check("b_rst_sck", spi_sck3, 0);
    check("b_rst_busy", busy3, 0);
    tick(2);
    aresetn = 1'b1;
    tick(60);
    check("b_rst_no_beat", got3_n, 1);
    check("b_rst_tvalid", m_axis3.tvalid, 0);
    check("b_rst_flags", {spi_sdo3, overrun3, trig_miss3}, 0);
    check("b_s_tready", s_axis3.tready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
